// File: rtl/uart_fpga_pkg.sv
// Shared types and helpers for the FPGA-side LArPix serial link.
package uart_fpga_pkg;

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Start bit + data bits + stop bit.
  function automatic int frame_bits(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/uart_fpga_rx_core.sv
// Receive path: 2-FF synchronizer, start/data/stop FSM, baud and bit counters, shift register.
// UART_FPGA_PARITY_CHECK_EN enables the odd-parity XOR tree; otherwise parity_ok is tied 1.
module uart_fpga_rx_core
  import uart_fpga_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_in,
  output logic [WIDTH-2:0] payload,
  output logic             parity_ok,
  output logic             word_valid
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  rx_state_t        state;
  logic             sync_meta;
  logic             sync_line;
  logic             wait_high;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta  <= 1'b1;
      sync_line  <= 1'b1;
      state      <= RX_IDLE;
      wait_high  <= 1'b0;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      word_valid <= 1'b0;
    end else begin
      sync_meta  <= rx_in;
      sync_line  <= sync_meta;
      word_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          // After a framing error the line must return high before a new start is accepted.
          if (wait_high) begin
            if (sync_line) wait_high <= 1'b0;
          end else if (!sync_line) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= sync_line ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {sync_line, shreg[WIDTH-1:1]};
            if (bit_cnt == BIT_LAST) state <= RX_STOP;
            else bit_cnt <= bit_cnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (sync_line) word_valid <= 1'b1;
            else wait_high <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign payload = shreg[WIDTH-2:0];

`ifdef UART_FPGA_PARITY_CHECK_EN
  assign parity_ok = ^shreg;
`else
  assign parity_ok = 1'b1;
`endif

endmodule

// File: rtl/uart_fpga_link.sv
// FPGA-side LArPix link: posi transmitter FSM plus piso receiver with a one-word holding register.
// Parity checking of received words is enabled by defining UART_FPGA_PARITY_CHECK_EN.
module uart_fpga_link
  import uart_fpga_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_enable,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             ld_tx_data,
  output logic             tx_out,
  output logic             tx_busy,
  input  logic             rx_in,
  input  logic             uld_rx_data,
  output logic [WIDTH-2:0] rx_data,
  output logic             rx_empty,
  output logic             parity_error
);

  localparam int FRAME = frame_bits(WIDTH);
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int FB_W  = $clog2(FRAME);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FB_W-1:0]  FB_LAST  = FB_W'(FRAME - 1);

  tx_state_t        tx_state;
  logic             ld_prev;
  logic [WIDTH:0]   tx_shreg;
  logic [CNT_W-1:0] tx_cnt;
  logic [FB_W-1:0]  tx_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_out   <= 1'b1;
      tx_busy  <= 1'b0;
      ld_prev  <= 1'b0;
      tx_shreg <= '0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else begin
      ld_prev <= ld_tx_data;
      case (tx_state)
        TX_IDLE: begin
          if (ld_tx_data && !ld_prev && tx_enable) begin
            tx_state <= TX_SHIFT;
            tx_busy  <= 1'b1;
            tx_out   <= 1'b0;
            // Stop bit rides above the data so it falls out after the last data bit.
            tx_shreg <= {1'b1, tx_data};
            tx_cnt   <= '0;
            tx_bit   <= '0;
          end
        end
        TX_SHIFT: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == FB_LAST) begin
              tx_state <= TX_IDLE;
              tx_busy  <= 1'b0;
              tx_out   <= 1'b1;
            end else begin
              tx_out   <= tx_shreg[0];
              tx_shreg <= {1'b0, tx_shreg[WIDTH:1]};
              tx_bit   <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  logic [WIDTH-2:0] payload;
  logic             parity_ok;
  logic             word_valid;

  uart_fpga_rx_core #(
    .WIDTH        (WIDTH),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .payload    (payload),
    .parity_ok  (parity_ok),
    .word_valid (word_valid)
  );

  // A new word always wins over an unload in the same cycle, and overwrites an unread one.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data      <= '0;
      rx_empty     <= 1'b1;
      parity_error <= 1'b0;
    end else if (word_valid) begin
      rx_data      <= payload;
      rx_empty     <= 1'b0;
      parity_error <= ~parity_ok;
    end else if (uld_rx_data) begin
      rx_empty <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_fpga_link.sv
// Randomized bench for uart_fpga_link: loopback and injected-line frames against a queue model.
`timescale 1ns/1ps
module tb_uart_fpga_link;

  localparam int WIDTH     = 64;
  localparam int CPB       = 4;
  localparam int FRAME_CYC = (WIDTH + 2) * CPB;
`ifdef UART_FPGA_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             tx_enable;
  logic [WIDTH-1:0] tx_data;
  logic             ld_tx_data;
  logic             tx_out;
  logic             tx_busy;
  logic             rx_in;
  logic             uld_rx_data;
  logic [WIDTH-2:0] rx_data;
  logic             rx_empty;
  logic             parity_error;

  logic loop_en;
  logic inj_line;
  logic mon_en = 1'b0;
  int   mon_full_cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [WIDTH-1:0] exp_q[$];

  assign rx_in = loop_en ? tx_out : inj_line;

  always #5 clk = ~clk;

  uart_fpga_link #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_enable    (tx_enable),
    .tx_data      (tx_data),
    .ld_tx_data   (ld_tx_data),
    .tx_out       (tx_out),
    .tx_busy      (tx_busy),
    .rx_in        (rx_in),
    .uld_rx_data  (uld_rx_data),
    .rx_data      (rx_data),
    .rx_empty     (rx_empty),
    .parity_error (parity_error)
  );

  always @(negedge clk) if (mon_en && !rx_empty) mon_full_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic exp_parity(input logic [WIDTH-1:0] w);
    int ones = 0;
    for (int i = 0; i < WIDTH; i++) if (w[i]) ones++;
    return PAR_EN && (ones % 2 == 0);
  endfunction

  function automatic logic frame_bit(input logic [WIDTH-1:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= WIDTH) return w[idx-1];
    return 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ld(input logic [WIDTH-1:0] w);
    tx_data    = w;
    ld_tx_data = 1'b1;
    @(negedge clk);
    ld_tx_data = 1'b0;
  endtask

  // Sends one word, checks every bit centre on tx_out and the busy length.
  task automatic send_frame(input string tag, input logic [WIDTH-1:0] w);
    int c = 0;
    @(negedge clk);
    if (loop_en) exp_q.push_back(w);
    pulse_ld(w);
    while (tx_busy === 1'b1 && c < FRAME_CYC + 50) begin
      if (c % CPB == CPB / 2 && c / CPB < WIDTH + 2)
        check({tag, "_bit"}, 64'(tx_out), 64'(frame_bit(w, c / CPB)));
      c++;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, 64'(c), 64'(FRAME_CYC));
    check({tag, "_idle_out"}, 64'(tx_out), 64'(1));
  endtask

  task automatic expect_delivery(input string tag);
    int c = 0;
    logic [WIDTH-1:0] w;
    while (rx_empty && c < 60) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_full"}, 64'(rx_empty), 64'(0));
    w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_data"}, 64'(rx_data), 64'(w[WIDTH-2:0]));
    check({tag, "_parity"}, 64'(parity_error), 64'(exp_parity(w)));
    uld_rx_data = 1'b1;
    @(negedge clk);
    uld_rx_data = 1'b0;
    check({tag, "_uld_empty"}, 64'(rx_empty), 64'(1));
    check({tag, "_uld_hold"}, 64'(rx_data), 64'(w[WIDTH-2:0]));
  endtask

  task automatic inject_frame(input logic [WIDTH-1:0] w, input logic stop_bit);
    for (int i = 0; i < WIDTH + 2; i++) begin
      inj_line = (i == WIDTH + 1) ? stop_bit : frame_bit(w, i);
      repeat (CPB) @(negedge clk);
    end
    inj_line = 1'b1;
  endtask

  initial begin
    logic [WIDTH-1:0] a, b;
    int c, frames, seen;
    logic prev;

    reset = 1'b1; tx_enable = 1'b0; ld_tx_data = 1'b0; uld_rx_data = 1'b0;
    tx_data = '0; loop_en = 1'b1; inj_line = 1'b1;
    cyc(3);
    check("rst_tx_out", 64'(tx_out), 64'(1));
    check("rst_tx_busy", 64'(tx_busy), 64'(0));
    check("rst_rx_empty", 64'(rx_empty), 64'(1));
    check("rst_rx_data", 64'(rx_data), 64'(0));
    check("rst_parity", 64'(parity_error), 64'(0));
    reset = 1'b0; tx_enable = 1'b1;
    cyc(2);

    send_frame("msb", 64'h8000_0000_0000_0000);
    expect_delivery("msb");
    send_frame("three", 64'h0000_0000_0000_0003);
    expect_delivery("three");
    for (int i = 0; i < 6; i++) begin
      send_frame("rnd", rand_word());
      expect_delivery("rnd");
    end

    // Level-held load must produce a single frame.
    a = rand_word();
    exp_q.push_back(a);
    tx_data = a; ld_tx_data = 1'b1; frames = 0; prev = 1'b0;
    repeat (600) begin
      @(negedge clk);
      if (tx_busy && !prev) frames++;
      prev = tx_busy;
    end
    ld_tx_data = 1'b0;
    check("hold_frames", 64'(frames), 64'(1));
    expect_delivery("hold");

    // Load while busy is dropped; disabling mid-frame does not abort.
    a = rand_word(); b = rand_word();
    exp_q.push_back(a);
    cyc(2);
    pulse_ld(a);
    c = 0;
    while (tx_busy === 1'b1 && c < 2 * FRAME_CYC) begin
      if (c == 100) begin tx_data = b; ld_tx_data = 1'b1; end
      if (c == 101) ld_tx_data = 1'b0;
      if (c == 150) tx_enable = 1'b0;
      c++;
      @(negedge clk);
    end
    check("drop_busy_len", 64'(c), 64'(FRAME_CYC));
    expect_delivery("drop");
    seen = 0;
    repeat (300) begin @(negedge clk); if (tx_busy) seen++; end
    check("drop_no_retx", 64'(seen), 64'(0));

    pulse_ld(rand_word());
    seen = 0;
    repeat (300) begin @(negedge clk); if (tx_busy || !tx_out) seen++; end
    check("disabled_ignored", 64'(seen), 64'(0));
    check("disabled_rx_empty", 64'(rx_empty), 64'(1));
    tx_enable = 1'b1;

    // Injected line tests.
    loop_en = 1'b0;
    cyc(4);
    inject_frame(rand_word(), 1'b0);
    cyc(30);
    check("framing_err_empty", 64'(rx_empty), 64'(1));
    a = rand_word();
    exp_q.push_back(a);
    inject_frame(a, 1'b1);
    expect_delivery("after_ferr");

    inj_line = 1'b0;
    cyc(1);
    inj_line = 1'b1;
    cyc(300);
    check("glitch_empty", 64'(rx_empty), 64'(1));

    a = rand_word(); b = rand_word();
    inject_frame(a, 1'b1);
    inject_frame(b, 1'b1);
    cyc(12);
    check("b2b_full", 64'(rx_empty), 64'(0));
    check("b2b_overrun_data", 64'(rx_data), 64'(b[WIDTH-2:0]));
    check("b2b_overrun_parity", 64'(parity_error), 64'(exp_parity(b)));
    uld_rx_data = 1'b1;
    @(negedge clk);
    uld_rx_data = 1'b0;
    check("b2b_uld", 64'(rx_empty), 64'(1));

    // Unload held high across a delivery: the word appears for exactly one cycle.
    a = rand_word();
    uld_rx_data = 1'b1; mon_full_cnt = 0; mon_en = 1'b1;
    inject_frame(a, 1'b1);
    cyc(20);
    mon_en = 1'b0; uld_rx_data = 1'b0;
    check("uld_vs_deliv_cycles", 64'(mon_full_cnt), 64'(1));
    check("uld_vs_deliv_data", 64'(rx_data), 64'(a[WIDTH-2:0]));
    check("uld_vs_deliv_empty", 64'(rx_empty), 64'(1));

    // Reset in the middle of a loopback frame.
    loop_en = 1'b1;
    cyc(4);
    pulse_ld(rand_word());
    cyc(100);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_tx_out", 64'(tx_out), 64'(1));
    check("midrst_tx_busy", 64'(tx_busy), 64'(0));
    reset = 1'b0;
    cyc(400);
    check("midrst_rx_empty", 64'(rx_empty), 64'(1));
    check("midrst_rx_data", 64'(rx_data), 64'(0));
    check("model_queue_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
